// File: rtl/aes_key_sched.sv
// ---------------------------------------------------------------------------
// aes_key_sched
//
// AES-128 key schedule that computes round keys on the fly. It accepts one
// 128-bit cipher key and then streams round keys 0..10 in order, one per
// accepted transfer. Each key is derived from the previous one, so the block
// stores no key table. It feeds the round_key input of aes_core.
// rk_last marks round key 10 and drives aes_core last_round.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous, active-high reset
//   key_in     in   128  cipher key; byte 0 at [127:120], word w0 = [127:96]
//   key_valid  in   1    key_in valid
//   key_ready  out  1    a key can be accepted (high only in IDLE)
//   rk_data    out  128  current round key, same byte order as aes_core state
//   rk_index   out  4    round number of rk_data, 0..10
//   rk_last    out  1    high while rk_index == 10
//   rk_valid   out  1    rk_data valid
//   rk_ready   in   1    consumer accepts rk_data
//   busy       out  1    high while round keys are being emitted
// ---------------------------------------------------------------------------
module aes_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e         state_q;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_index_q;
  logic           rk_last_q;
  logic           rk_valid_q;
  logic           key_ready_q;
  logic           busy_q;

  // Combinational next round key, derived only from the rk_data register.
  logic [127:0]   rk_data_d;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_word;
  logic [31:0]    sub_word;
  logic [31:0]    t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [3:0]     rcon_idx;
  logic [7:0]     rcon;

  assign w0 = rk_data_q[127:96];
  assign w1 = rk_data_q[95:64];
  assign w2 = rk_data_q[63:32];
  assign w3 = rk_data_q[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  // Four byte-wide S-box lookups form SubWord.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_word[8*b +: 8] = SBOX[rot_word[8*b +: 8]];
  end

  // The round constant comes from a fixed table indexed by the round being
  // produced. Index 11 and above, and the 4-bit wrap to 0, select zero.
  assign rcon_idx = rk_index_q + 4'd1;

  always_comb begin
    // NOTE: rcon gets a default first, so every path assigns it and no latch is inferred.
    rcon = 8'h00;
    case (rcon_idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_word    = sub_word ^ {rcon, 24'h000000};
  assign n0        = w0 ^ t_word;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign rk_data_d = {n0, n1, n2, n3};

  // Control FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      rk_data_q   <= '0;
      rk_index_q  <= '0;
      rk_last_q   <= 1'b0;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            rk_data_q   <= key_in;
            rk_index_q  <= '0;
            rk_last_q   <= 1'b0;
            rk_valid_q  <= 1'b1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          // Without a handshake everything holds, so backpressure leaves
          // rk_data, rk_index and rk_last untouched.
          if (rk_valid_q && rk_ready) begin
            if (rk_index_q == LAST_ROUND) begin
              // The final handshake ends the stream. key_ready rises on the
              // next cycle, so a key cannot be taken in this same cycle.
              rk_valid_q  <= 1'b0;
              rk_last_q   <= 1'b0;
              busy_q      <= 1'b0;
              key_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              rk_data_q  <= rk_data_d;
              rk_index_q <= rk_index_q + 4'd1;
              rk_last_q  <= (rk_index_q == LAST_ROUND - 4'd1);
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          rk_valid_q  <= 1'b0;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rk_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign rk_data   = rk_data_q;
  assign rk_index  = rk_index_q;
  assign rk_last   = rk_last_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched
//
// Self-checking bench for aes_key_sched. The reference model builds the AES
// S-box from GF(2^8) inversion plus the affine map. It expands keys word by
// word with a doubling round constant. It then encrypts one block with the
// streamed round keys for an end-to-end check.
// ---------------------------------------------------------------------------
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  aes_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    if (v != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        logic [7:0] xb;
        xb = x[7:0];
        if (gmul(v, xb) == 8'h01) inv = xb;
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Full AES-128 encryption using the round keys captured from the DUT.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ got_rk[0][127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ got_rk[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    return ct;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic load_key(input logic [127:0] k);
    check("key_ready_idle", key_ready, 1);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("rk0_valid", rk_valid, 1);
    check("rk0_index", rk_index, 0);
    check("rk0_data", rk_data, k);
    check("busy_emit", busy, 1);
    check("key_ready_emit", key_ready, 0);
  endtask

  task automatic run_stream(input bit rand_ready, input bit inject, input logic [127:0] inj_key,
                            output int n_xfer, output int n_cycles);
    logic [127:0] pd;
    logic [3:0]   pi;
    logic         pl;
    bit           stalled;
    stalled  = 1'b0;
    n_xfer   = 0;
    n_cycles = 0;
    pd = '0; pi = '0; pl = 1'b0;
    for (int i = 0; i < 11; i++) got_rk[i] = '0;
    while (n_xfer < 11 && n_cycles < 400) begin
      if (stalled) begin
        check("stall_data", rk_data, pd);
        check("stall_index", rk_index, pi);
        check("stall_last", rk_last, pl);
      end
      check("valid_in_stream", rk_valid, 1);
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && n_cycles == 3) begin
        key_in    = inj_key;
        key_valid = 1'b1;
        check("key_ready_busy", key_ready, 0);
      end else begin
        key_valid = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        check("xfer_index", rk_index, n_xfer);
        check("xfer_last", rk_last, (n_xfer == 10));
        if (rk_index <= 4'd10) got_rk[rk_index] = rk_data;
        n_xfer++;
        stalled = 1'b0;
      end else begin
        stalled = rk_valid;
        pd = rk_data; pi = rk_index; pl = rk_last;
      end
      @(negedge clk);
      n_cycles++;
    end
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    if (n_xfer < 11) check("stream_timeout_xfers", n_xfer, 11);
    check("end_valid", rk_valid, 0);
    check("end_key_ready", key_ready, 1);
    check("end_busy", busy, 0);
    check("end_last", rk_last, 0);
  endtask

  task automatic compare_model(input string tag);
    for (int r = 0; r < 11; r++) check(tag, got_rk[r], exp_rk[r]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nx, nc;
    logic [127:0] rkey;

    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_math(i[7:0]);

    vecs[0] = '{KEY_A, 0,  KEY_A};
    vecs[1] = '{KEY_A, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{KEY_A, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{KEY_A, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{KEY_C, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_key_ready", key_ready, 1);
    check("rst_valid", rk_valid, 0);
    check("rst_data", rk_data, 0);
    check("rst_index", rk_index, 0);
    check("rst_last", rk_last, 0);
    check("rst_busy", busy, 0);

    // rk_ready in IDLE does nothing.
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_valid", rk_valid, 0);
    check("idle_ready_index", rk_index, 0);
    rk_ready = 1'b0;

    // Known-answer vectors with rk_ready held high.
    foreach (vecs[v]) begin
      load_key(vecs[v].key);
      run_stream(1'b0, 1'b0, '0, nx, nc);
      check("kat_cycles", nc, 11);
      check($sformatf("kat_round%0d", vecs[v].round), got_rk[vecs[v].round], vecs[v].rk);
      @(negedge clk);
    end

    // End-to-end encryption using the App. A round keys.
    load_key(KEY_A);
    run_stream(1'b0, 1'b0, '0, nx, nc);
    check("e2e_cipher", aes_enc(128'h3243f6a8885a308d313198a2e0370734),
          128'h3925841d02dc09fbdc118597196a0b32);
    @(negedge clk);

    // Backpressure on App. A.
    expand(KEY_A);
    load_key(KEY_A);
    run_stream(1'b1, 1'b0, '0, nx, nc);
    compare_model("bp_keyA");
    @(negedge clk);

    // Key pulse during EMIT is ignored.
    load_key(KEY_A);
    run_stream(1'b1, 1'b1, KEY_C, nx, nc);
    compare_model("inject_keyA");
    @(negedge clk);

    // Reset after the round-4 transfer, with key_valid raised at the same time.
    load_key(KEY_A);
    rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_index", rk_index, 5);
    rst = 1'b1; key_valid = 1'b1; key_in = KEY_C;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
    check("midrst_valid", rk_valid, 0);
    check("midrst_key_ready", key_ready, 1);
    check("midrst_index", rk_index, 0);
    check("midrst_busy", busy, 0);
    check("midrst_last", rk_last, 0);
    @(negedge clk);
    check("midrst_no_accept", rk_valid, 0);
    expand(KEY_C);
    load_key(KEY_C);
    run_stream(1'b0, 1'b0, '0, nx, nc);
    compare_model("post_rst_keyC");
    @(negedge clk);

    // Randomized keys under random backpressure.
    for (int k = 0; k < 4; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey);
      load_key(rkey);
      run_stream(1'b1, 1'b0, '0, nx, nc);
      compare_model("rand_key");
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- AES-128 on-the-fly key schedule. It sits directly upstream of the aes_core round datapath and supplies its round_key input.
- Accepts one 128-bit cipher key through a valid/ready handshake.
- Streams round keys 0..10 in order through a second valid/ready handshake.
- rk_last marks round key 10, and is wired to aes_core last_round by the round controller.
- Computes one round key per accepted transfer using 4 sbox instances (SubWord of RotWord). No stored key table.

Parameters:
- None. AES-128 only; Rcon sequence is fixed.

Ports:
- clk       input   1    system clock, rising edge
- rst       input   1    synchronous, active-high reset
- key_in    input   128  cipher key; byte 0 at [127:120], word w0 = [127:96]
- key_valid input   1    key_in valid
- key_ready output  1    block can accept a key (high only in IDLE)
- rk_data   output  128  current round key, same byte order as aes_core state
- rk_index  output  4    round number of rk_data, 0..10
- rk_last   output  1    high when rk_index == 10 (drives aes_core last_round)
- rk_valid  output  1    rk_data valid
- rk_ready  input   1    consumer accepts rk_data
- busy      output  1    high while in EMIT

Behaviour:
- One clock domain. Synchronous, active-high reset. All outputs registered.
- Reset values: key_ready=1 (IDLE), rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0.
- States: IDLE, EMIT.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid && key_ready: rk_data<=key_in, rk_index<=0, rk_valid<=1, busy<=1, go to EMIT.
  - Round key 0 is visible the cycle after acceptance (latency 1).
- EMIT:
  - key_ready=0; key_valid is ignored.
  - rk_data, rk_index and rk_last are held stable while rk_valid && !rk_ready (no change under backpressure).
  - On rk_valid && rk_ready with rk_index < 10: rk_data <= next(rk_data, rcon[rk_index+1]) and rk_index increments. rk_valid stays 1, so consecutive transfers run at 1 key/cycle when rk_ready is held high.
  - On rk_valid && rk_ready with rk_index == 10: rk_valid<=0, busy<=0, rk_last<=0, go to IDLE. key_ready=1 the following cycle.
  - A new key therefore cannot be accepted in the same cycle as the final handshake.
- rk_last is registered. It goes high together with rk_index becoming 10 and low when the round-10 handshake completes.
- next(rk, rc), with w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0]:
  - rot = {w3[23:0], w3[31:24]}
  - sub = per-byte sbox(rot)
  - t = sub ^ {rc, 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - result = {n0, n1, n2, n3}
  - The function is purely combinational from the rk_data register; the sbox path is registered on the handshake.
- Rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Selected by rk_index+1 through a case table. No GF doubling chain.
  - Index values outside 1..10 select 00.
- Reset asserted mid-stream (any state, any handshake condition): return to reset values next edge. The partial stream is abandoned with no further rk_valid.
- Simultaneous rst and key_valid: reset wins; the key is not accepted.
- rk_ready high in IDLE has no effect.

Test Plan:
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 held:
  - round 0 = key, one cycle after acceptance.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - exactly 11 transfers in 11 consecutive cycles, then key_ready=1.
- FIPS-197 App. C.1 key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Backpressure: random rk_ready with ~50% duty on the App. A key -> same 11 keys in order. rk_data, rk_index and rk_last stay stable every cycle that rk_valid=1 and rk_ready=0.
- key_valid pulsed with a different key during EMIT -> ignored (key_ready=0); the stream completes with the original key's values.
- rst asserted after round-4 transfer -> next cycle rk_valid=0, key_ready=1, rk_index=0. A fresh App. C.1 load then produces its correct sequence from round 0.
- End-to-end: chain to aes_core with plaintext 3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c -> ciphertext 3925841d02dc09fbdc118597196a0b32.
